// File: rtl/div_repeated_sub.sv
// div_repeated_sub: sequential unsigned divider by repeated subtraction, with a start/done handshake
module div_repeated_sub #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         done,
  output logic         dz
);
  typedef enum logic [2:0] {IDLE, LDA, LDB, SUB, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] q_q, q_d, r_q, r_d, b_q, b_d;
  logic dz_q, dz_d;
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    b_d     = b_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: state_d = start ? LDA : IDLE;
      LDA: begin
        r_d     = data_in;
        q_d     = '0;
        dz_d    = 1'b0;
        state_d = LDB;
      end
      LDB: begin
        b_d     = data_in;
        state_d = SUB;
      end
      SUB: begin
        // a zero divisor exits immediately, leaving the dividend in R
        if (b_q == '0) begin
          dz_d    = 1'b1;
          q_d     = '0;
          state_d = DONE;
        end else if (r_q >= b_q) begin
          r_d = r_q - b_q;
          q_d = q_q + W'(1);
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = start ? LDA : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      b_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      b_q     <= b_d;
      dz_q    <= dz_d;
    end
  end
  assign quotient  = q_q;
  assign remainder = r_q;
  assign dz        = dz_q;
  assign done      = (state_q == DONE);
endmodule

// File: tb/tb_div_repeated_sub.sv
// tb_div_repeated_sub: table, directed and random checks of div_repeated_sub against an arithmetic model
module tb_div_repeated_sub;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] quotient, remainder;
  logic        done, dz;
  int tests = 0;
  int fails = 0;

  div_repeated_sub #(.W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
    .quotient(quotient), .remainder(remainder), .done(done), .dz(dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b, q, r;
    bit dz;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called #1 after a rising edge; leaves the bench #1 after a rising edge.
  task automatic op(input logic [15:0] a, input logic [15:0] b, input string nm,
                    input bit pulse, input bit restart);
    int lat, e;
    logic [15:0] eq, er;
    bit edz;
    edz = (b == 16'd0);
    eq  = edz ? 16'd0 : a / b;
    er  = edz ? a : a % b;
    lat = edz ? 3 : int'(eq) + 3;
    start = 1'b1;
    data_in = 16'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    data_in = a;
    if (restart) chk({nm, " done_drop"}, done, 0);
    @(posedge clk); #1;
    data_in = b;
    @(posedge clk); #1;
    data_in = 16'($urandom);
    e = 2;
    while (!done && e < lat + 20) begin
      start = pulse && (e <= lat - 1) && (e % 997 == 0);
      @(posedge clk); #1;
      e++;
    end
    start = 1'b0;
    chk({nm, " latency"}, e, lat);
    chk({nm, " done"}, done, 1);
    chk({nm, " quotient"}, quotient, eq);
    chk({nm, " remainder"}, remainder, er);
    chk({nm, " dz"}, dz, edz);
    repeat (2) @(posedge clk);
    #1;
    chk({nm, " hold_done"}, done, 1);
    chk({nm, " hold_q"}, quotient, eq);
    chk({nm, " hold_r"}, remainder, er);
  endtask

  initial begin
    vec_t tbl[7];
    tbl[0] = '{a: 16'd17,   b: 16'd5, q: 16'd3, r: 16'd2,    dz: 1'b0};
    tbl[1] = '{a: 16'd4,    b: 16'd9, q: 16'd0, r: 16'd4,    dz: 1'b0};
    tbl[2] = '{a: 16'd1000, b: 16'd0, q: 16'd0, r: 16'd1000, dz: 1'b1};
    tbl[3] = '{a: 16'd36,   b: 16'd6, q: 16'd6, r: 16'd0,    dz: 1'b0};
    tbl[4] = '{a: 16'd0,    b: 16'd5, q: 16'd0, r: 16'd0,    dz: 1'b0};
    tbl[5] = '{a: 16'd5,    b: 16'd5, q: 16'd1, r: 16'd0,    dz: 1'b0};
    tbl[6] = '{a: 16'd0,    b: 16'd0, q: 16'd0, r: 16'd0,    dz: 1'b1};
    #1;
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset done", done, 0);
    chk("reset dz", dz, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) begin
      op(tbl[i].a, tbl[i].b, $sformatf("vec%0d", i), 1'b0, i != 0);
      chk($sformatf("vec%0d table_q", i), quotient, tbl[i].q);
      chk($sformatf("vec%0d table_r", i), remainder, tbl[i].r);
      chk($sformatf("vec%0d table_dz", i), dz, tbl[i].dz);
    end
    op(16'd65535, 16'd1, "max_div1", 1'b1, 1'b1);
    for (int i = 0; i < 25; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = (i % 5 == 4) ? 16'd0 : 16'($urandom_range(65535, int'(a) / 50 + 1));
      op(a, b, $sformatf("rand%0d_%0d/%0d", i, a, b), 1'b0, 1'b1);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    data_in = 16'd200;
    @(posedge clk); #1;
    data_in = 16'd7;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst quotient", quotient, 0);
    chk("midrst remainder", remainder, 0);
    chk("midrst done", done, 0);
    chk("midrst dz", dz, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("postrst idle", done, 0);
    op(16'd100, 16'd10, "after_rst", 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
